// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the data-memory port arbiter
package mips_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
   typedef enum logic {GNT_IF, GNT_MEM} grant_e;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of MEM grants taken while IF was waiting
module arb_starve_ctr
   import mips_pkg::*;
#(
   parameter int MAX = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);
   localparam int CW = $clog2(MAX + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && !at_max) cnt <= cnt + CW'(1);
   assign at_max = cnt >= CW'(MAX);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port data RAM between IF fetches and MEM loads/stores
module dmem_port_arbiter
   import mips_pkg::*;
#(
   parameter int DEPTH       = 32,
   parameter int RAM_LAT     = 1,
   parameter int IF_MAX_WAIT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     if_req,
   input  logic [31:0]              if_addr,
   output logic                     if_done,
   output logic [31:0]              if_rdata,
   input  logic                     mem_req,
   input  logic                     mem_we,
   input  logic [31:0]              mem_addr,
   input  logic [31:0]              mem_wdata,
   output logic                     mem_done,
   output logic [31:0]              mem_rdata,
   output logic                     addr_err,
   output logic                     stall,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [$clog2(DEPTH)-1:0] ram_addr,
   output logic [31:0]              ram_wdata,
   input  logic [31:0]              ram_rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
   arb_state_e st, st_n;
   grant_e gnt;
   logic we_q, err_q, at_max, sel_if, we_in, err_in, grant, starve_inc, starve_clr;
   logic [AW-1:0] idx_q;
   logic [31:0] wdata_q, sel_addr;
   logic [LW-1:0] lat_cnt;
   assign sel_if = if_req & (~mem_req | at_max);
   assign sel_addr = sel_if ? if_addr : mem_addr;
   assign we_in = ~sel_if & mem_we;
   assign err_in = ((sel_addr % 32'(WORD_BYTES)) != '0) || ((sel_addr / 32'(WORD_BYTES)) >= 32'(DEPTH));
   assign grant = (st == IDLE) & (if_req | mem_req);
   assign starve_inc = grant & ~sel_if & if_req;
   assign starve_clr = (st == IDLE) & (~if_req | sel_if);
   arb_starve_ctr #(.MAX(IF_MAX_WAIT)) u_starve (
      .clk(clk), .rst_n(rst_n), .inc(starve_inc), .clr(starve_clr), .at_max(at_max)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= IDLE;
      else st <= st_n;
   always_comb begin
      st_n = st;
      case (st)
         IDLE:  if (grant) st_n = err_in ? RESP : ISSUE;
         ISSUE: st_n = we_q ? RESP : WAIT;
         WAIT:  if (lat_cnt == '0) st_n = RESP;
         RESP:  st_n = IDLE;
      endcase
   end
   // rdata registers load on the edge into RESP, so they change exactly with done
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gnt       <= GNT_IF;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         lat_cnt   <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else begin
         if (grant) begin
            gnt     <= sel_if ? GNT_IF : GNT_MEM;
            we_q    <= we_in;
            err_q   <= err_in;
            idx_q   <= sel_addr[AW+1:2];
            wdata_q <= we_in ? mem_wdata : '0;
            if (err_in && sel_if) if_rdata <= '0;
            if (err_in && !sel_if) mem_rdata <= '0;
         end
         if (st == ISSUE) lat_cnt <= LW'(RAM_LAT - 1);
         if (st == WAIT) begin
            lat_cnt <= lat_cnt - LW'(1);
            if (lat_cnt == '0 && gnt == GNT_IF) if_rdata <= ram_rdata;
            if (lat_cnt == '0 && gnt == GNT_MEM) mem_rdata <= ram_rdata;
         end
      end
   assign ram_en    = st == ISSUE;
   assign ram_we    = ram_en & we_q;
   assign ram_addr  = ram_en ? idx_q : '0;
   assign ram_wdata = ram_en ? wdata_q : '0;
   assign if_done   = (st == RESP) & (gnt == GNT_IF);
   assign mem_done  = (st == RESP) & (gnt == GNT_MEM);
   assign addr_err  = (st == RESP) & err_q;
   assign stall     = rst_n & ((if_req & ~if_done) | (mem_req & ~mem_done));
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_dmem_port_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
   logic if_done, mem_done, addr_err, stall, ram_en, ram_we;
   logic [31:0] if_rdata, mem_rdata, ram_wdata;
   logic [4:0] ram_addr;
   logic [31:0] ram_rdata = '0;
   logic [31:0] ram [32];
   logic [31:0] ref_mem [32];
   logic pl_en = 1'b0;
   int chk = 0, pass = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .addr_err(addr_err), .stall(stall),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // RAM macro stand-in with one cycle of read latency; pl_en preloads the reference image
   always @(posedge clk) begin
      if (pl_en) for (int i = 0; i < 32; i++) ram[i] <= ref_mem[i];
      else if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else ram_rdata <= ram[ram_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic sync_ram;
      pl_en = 1'b1;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic do_reset;
      if_req = 1'b0;
      mem_req = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 9);
      logic [31:0] w = 32'($urandom_range(0, 7)) << 2;
      if (r == 0) return w | 32'($urandom_range(1, 3));
      if (r == 1) return ($urandom | 32'h80) & ~32'h3;
      return w;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      if_req = 1'b1;
      mem_req = 1'b1;
      tick();
      chk++; if ({ram_en, ram_we, if_done, mem_done, addr_err} !== 5'b0) $display("FAIL reset_ctrl got %b exp 00000", {ram_en, ram_we, if_done, mem_done, addr_err}); else pass++;
      chk++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else pass++;
      chk++; if ({if_rdata, mem_rdata} !== 64'h0) $display("FAIL reset_rdata got %h exp 0", {if_rdata, mem_rdata}); else pass++;
      chk++; if ({ram_addr, ram_wdata} !== 37'h0) $display("FAIL reset_ram_bus got %h exp 0", {ram_addr, ram_wdata}); else pass++;
      if_req = 1'b0;
      mem_req = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load;
      mem_we = 1'b0;
      mem_addr = 32'h10;
      mem_req = 1'b1;
      #1;
      chk++; if (stall !== 1'b1) $display("FAIL load_stall_c0 got %b exp 1", stall); else pass++;
      chk++; if (ram_en !== 1'b0) $display("FAIL load_en_c0 got %b exp 0", ram_en); else pass++;
      tick();
      chk++; if ({ram_en, ram_we} !== 2'b10) $display("FAIL load_en_c1 got %b exp 10", {ram_en, ram_we}); else pass++;
      chk++; if (ram_addr !== 5'd4) $display("FAIL load_addr got %0d exp 4", ram_addr); else pass++;
      tick();
      chk++; if ({stall, ram_en, mem_done} !== 3'b100) $display("FAIL load_c2 got %b exp 100", {stall, ram_en, mem_done}); else pass++;
      tick();
      chk++; if ({mem_done, addr_err, stall} !== 3'b100) $display("FAIL load_done got %b exp 100", {mem_done, addr_err, stall}); else pass++;
      chk++; if (mem_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata got %h exp deadbeef", mem_rdata); else pass++;
      mem_req = 1'b0;
      tick();
      chk++; if (mem_done !== 1'b0) $display("FAIL load_done_pulse got %b exp 0", mem_done); else pass++;
      chk++; if (mem_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata_hold got %h exp deadbeef", mem_rdata); else pass++;
   endtask

   task automatic test_store;
      mem_we = 1'b1;
      mem_addr = 32'h08;
      mem_wdata = 32'h12345678;
      mem_req = 1'b1;
      tick();
      chk++; if ({ram_en, ram_we} !== 2'b11) $display("FAIL store_en got %b exp 11", {ram_en, ram_we}); else pass++;
      chk++; if (ram_addr !== 5'd2) $display("FAIL store_addr got %0d exp 2", ram_addr); else pass++;
      chk++; if (ram_wdata !== 32'h12345678) $display("FAIL store_wdata got %h exp 12345678", ram_wdata); else pass++;
      tick();
      chk++; if ({mem_done, addr_err, ram_en} !== 3'b100) $display("FAIL store_done got %b exp 100", {mem_done, addr_err, ram_en}); else pass++;
      chk++; if ({ram_we, ram_wdata} !== 33'h0) $display("FAIL store_bus_idle got %h exp 0", {ram_we, ram_wdata}); else pass++;
      ref_mem[2] = 32'h12345678;
      mem_req = 1'b0;
      mem_we = 1'b0;
      tick();
      mem_req = 1'b1;
      tick();
      tick();
      tick();
      chk++; if (mem_done !== 1'b1) $display("FAIL store_readback_done got %b exp 1", mem_done); else pass++;
      chk++; if (mem_rdata !== 32'h12345678) $display("FAIL store_readback got %h exp 12345678", mem_rdata); else pass++;
      mem_req = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous;
      if_addr = 32'h14;
      mem_addr = 32'h18;
      mem_we = 1'b0;
      if_req = 1'b1;
      mem_req = 1'b1;
      tick();
      chk++; if ({ram_en, ram_addr} !== {1'b1, 5'd6}) $display("FAIL sim_mem_first got en=%b addr=%0d exp en=1 addr=6", ram_en, ram_addr); else pass++;
      tick();
      tick();
      chk++; if ({mem_done, if_done, stall} !== 3'b101) $display("FAIL sim_mem_done got %b exp 101", {mem_done, if_done, stall}); else pass++;
      chk++; if (mem_rdata !== ref_mem[6]) $display("FAIL sim_mem_rdata got %h exp %h", mem_rdata, ref_mem[6]); else pass++;
      mem_req = 1'b0;
      tick();
      chk++; if ({ram_en, stall} !== 2'b01) $display("FAIL sim_if_grant got %b exp 01", {ram_en, stall}); else pass++;
      tick();
      chk++; if ({ram_en, ram_addr} !== {1'b1, 5'd5}) $display("FAIL sim_if_issue got en=%b addr=%0d exp en=1 addr=5", ram_en, ram_addr); else pass++;
      tick();
      tick();
      chk++; if ({if_done, mem_done} !== 2'b10) $display("FAIL sim_if_done got %b exp 10", {if_done, mem_done}); else pass++;
      chk++; if (if_rdata !== ref_mem[5]) $display("FAIL sim_if_rdata got %h exp %h", if_rdata, ref_mem[5]); else pass++;
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_starvation;
      string got = "";
      if_addr = 32'h0;
      mem_addr = 32'h1C;
      mem_we = 1'b0;
      if_req = 1'b1;
      mem_req = 1'b1;
      for (int c = 0; c < 80 && got.len() < 8; c++) begin
         tick();
         if (if_done) got = {got, "I"};
         if (mem_done) got = {got, "M"};
      end
      if_req = 1'b0;
      mem_req = 1'b0;
      chk++; if (got != "MMMIMMMI") $display("FAIL starve_order got %s exp MMMIMMMI", got); else pass++;
      do_reset();
   endtask

   task automatic test_errors;
      logic [31:0] ea [3] = '{32'h06, 32'h80, 32'h7F};
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            if_addr = ea[i];
            if_req = 1'b1;
         end else begin
            mem_addr = ea[i];
            mem_we = (i == 1);
            mem_wdata = 32'hCAFE0000;
            mem_req = 1'b1;
         end
         #1;
         chk++; if (ram_en !== 1'b0) $display("FAIL err%0d_en_c0 got %b exp 0", i, ram_en); else pass++;
         tick();
         chk++; if ({ram_en, addr_err} !== 2'b01) $display("FAIL err%0d_c1 got en,err=%b exp 01", i, {ram_en, addr_err}); else pass++;
         chk++; if ({if_done, mem_done} !== ((i == 2) ? 2'b10 : 2'b01)) $display("FAIL err%0d_done got %b", i, {if_done, mem_done}); else pass++;
         chk++; if (((i == 2) ? if_rdata : mem_rdata) !== 32'h0) $display("FAIL err%0d_rdata got %h exp 0", i, (i == 2) ? if_rdata : mem_rdata); else pass++;
         if_req = 1'b0;
         mem_req = 1'b0;
         mem_we = 1'b0;
         tick();
         chk++; if ({addr_err, if_done, mem_done} !== 3'b0) $display("FAIL err%0d_pulse got %b exp 000", i, {addr_err, if_done, mem_done}); else pass++;
      end
   endtask

   task automatic test_reset_mid;
      for (int p = 1; p <= 2; p++) begin
         int seen = 0;
         mem_addr = 32'h10;
         mem_we = 1'b0;
         mem_req = 1'b1;
         repeat (p) tick();
         chk++; if (ram_en !== (p == 1)) $display("FAIL rmid%0d_pre_en got %b", p, ram_en); else pass++;
         rst_n = 1'b0;
         #1;
         chk++; if ({ram_en, stall, mem_done} !== 3'b0) $display("FAIL rmid%0d_drop got %b exp 000", p, {ram_en, stall, mem_done}); else pass++;
         chk++; if (mem_rdata !== 32'h0) $display("FAIL rmid%0d_rdata got %h exp 0", p, mem_rdata); else pass++;
         mem_req = 1'b0;
         tick();
         rst_n = 1'b1;
         repeat (4) begin
            tick();
            if (mem_done || ram_en) seen++;
         end
         chk++; if (seen != 0) $display("FAIL rmid%0d_abandon got %0d activity cycles exp 0", p, seen); else pass++;
         mem_req = 1'b1;
         tick();
         tick();
         tick();
         chk++; if ({mem_done, mem_rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL rmid%0d_recover got %b/%h exp 1/deadbeef", p, mem_done, mem_rdata); else pass++;
         mem_req = 1'b0;
         tick();
      end
   endtask

   // Model: one transaction at a time; grant in an idle cycle by priority, done after a fixed latency
   task automatic test_random;
      bit ip = 0, mp = 0, act = 0, gi = 0, e_err = 0, e_we = 0, xi, xm, xe, xen;
      int done_at = -1, en_at = -1, idle_from = 0, starve = 0;
      logic [31:0] e_rd = '0, e_wd = '0, x_if = '0, x_mem = '0, a;
      logic [4:0] e_idx = '0;
      do_reset();
      for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
      sync_ram();
      for (int t = 0; t < 600; t++) begin
         xi = act && gi && t == done_at;
         xm = act && !gi && t == done_at;
         xe = act && e_err && t == done_at;
         xen = act && !e_err && t == en_at;
         if (xi) x_if = e_err ? 32'h0 : e_rd;
         if (xm && (e_err || !e_we)) x_mem = e_err ? 32'h0 : e_rd;
         chk++; if (if_done !== xi) $display("FAIL rnd_if_done t=%0d got %b exp %b", t, if_done, xi); else pass++;
         chk++; if (mem_done !== xm) $display("FAIL rnd_mem_done t=%0d got %b exp %b", t, mem_done, xm); else pass++;
         chk++; if (addr_err !== xe) $display("FAIL rnd_addr_err t=%0d got %b exp %b", t, addr_err, xe); else pass++;
         chk++; if (ram_en !== xen) $display("FAIL rnd_ram_en t=%0d got %b exp %b", t, ram_en, xen); else pass++;
         chk++; if (if_rdata !== x_if) $display("FAIL rnd_if_rdata t=%0d got %h exp %h", t, if_rdata, x_if); else pass++;
         chk++; if (mem_rdata !== x_mem) $display("FAIL rnd_mem_rdata t=%0d got %h exp %h", t, mem_rdata, x_mem); else pass++;
         chk++; if (stall !== ((ip && !xi) || (mp && !xm))) $display("FAIL rnd_stall t=%0d got %b", t, stall); else pass++;
         if (xen) begin
            chk++; if ({ram_addr, ram_we} !== {e_idx, e_we}) $display("FAIL rnd_cmd t=%0d got addr=%0d we=%b exp addr=%0d we=%b", t, ram_addr, ram_we, e_idx, e_we); else pass++;
            chk++; if (ram_wdata !== (e_we ? e_wd : 32'h0)) $display("FAIL rnd_wdata t=%0d got %h", t, ram_wdata); else pass++;
         end else begin
            chk++; if ({ram_we, ram_wdata} !== 33'h0) $display("FAIL rnd_bus_idle t=%0d got %h exp 0", t, {ram_we, ram_wdata}); else pass++;
         end
         if (xi || xm) begin
            act = 0;
            idle_from = t + 1;
            if (xi) begin ip = 0; if_req = 1'b0; end
            else begin mp = 0; mem_req = 1'b0; end
         end
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1;
            if_addr = rand_addr();
            if_req = 1'b1;
         end
         if (!mp && $urandom_range(0, 2) == 0) begin
            mp = 1;
            mem_addr = rand_addr();
            mem_we = 1'($urandom_range(0, 1));
            mem_wdata = $urandom;
            mem_req = 1'b1;
         end
         if (!act && t >= idle_from) begin
            if (!ip) starve = 0;
            if (ip || mp) begin
               gi = ip && (!mp || starve >= 3);
               starve = gi ? 0 : (ip ? ((starve < 3) ? starve + 1 : 3) : starve);
               a = gi ? if_addr : mem_addr;
               e_we = !gi && mem_we;
               e_err = (a[1:0] != 2'b0) || (a >= 32'h80);
               e_idx = a[6:2];
               e_wd = mem_wdata;
               e_rd = ref_mem[e_idx];
               if (e_we && !e_err) ref_mem[e_idx] = e_wd;
               act = 1;
               en_at = t + 1;
               done_at = t + (e_err ? 1 : (e_we ? 2 : 3));
            end
         end
         tick();
      end
      if_req = 1'b0;
      mem_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = $urandom | 32'h1;
      ref_mem[4] = 32'hDEADBEEF;
      sync_ram();
      test_reset();
      test_load();
      test_store();
      test_simultaneous();
      test_starvation();
      test_errors();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end
endmodule
